// File: rtl/barrett_precompute_64b_pkg.sv
// barrett_precompute_64b_pkg: shared widths, iteration count and state encodings
package barrett_precompute_64b_pkg;
  localparam int MOD_W = 64;
  localparam int K_W = 7;
  localparam int U_W = 128;
  localparam int ITER = 129;
  typedef enum logic [1:0] {IDLE, CALC_K, DIV, DONE} state_t;
endpackage

// File: rtl/barrett_precompute_64b_bit_length.sv
// bit_length_64b: index of the highest set bit plus one, zero for zero input
module bit_length_64b (
  input  logic [63:0] x,
  output logic [6:0]  len
);
  always_comb begin
    len = '0;
    for (int i = 0; i < 64; i++) len = x[i] ? 7'(i + 1) : len;
  end
endmodule

// File: rtl/barrett_precompute_64b.sv
// barrett_precompute_64b: computes k = bitlen(q) and u = floor(2^(2k)/q) by restoring division
module barrett_precompute_64b
  import barrett_precompute_64b_pkg::*;
#(
  parameter int DATA_W = MOD_W
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  input  logic              iClr,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iMod,
  output logic              oValid,
  input  logic              iReady,
  output logic [K_W-1:0]    oK,
  output logic [U_W-1:0]    oU,
  output logic              oErr
);
  state_t state, state_nx;
  logic [DATA_W-1:0] q;
  logic [DATA_W:0] rem, rem_sh;
  logic [7:0] cnt;
  logic [K_W-1:0] k;
  logic err, qbit;
  bit_length_64b u_bl (.x(q), .len(k));
  always_comb begin
    oReady = state == IDLE;
    oValid = state == DONE;
    oErr = err & oValid;
    rem_sh = {rem[DATA_W-1:0], cnt == {k, 1'b0}};
    qbit = rem_sh >= {1'b0, q};
    state_nx = !iEn ? state :
               state == IDLE ? (iValid ? CALC_K : IDLE) :
               state == CALC_K ? DIV :
               state == DIV ? (cnt == 8'd0 ? DONE : DIV) :
               (iReady ? IDLE : DONE);
  end
  always_ff @(posedge iClk) begin
    if (iRst | iClr) begin
      state <= IDLE;
      q <= '0;
      rem <= '0;
      cnt <= '0;
      oK <= '0;
      oU <= '0;
      err <= 1'b0;
    end else if (iEn) begin
      state <= state_nx;
      if (state == IDLE && iValid) q <= iMod;
      if (state == CALC_K) begin
        oK <= k;
        oU <= '0;
        rem <= '0;
        err <= q[DATA_W-1:1] == '0;
        cnt <= q[DATA_W-1:1] == '0 ? 8'd0 : 8'(ITER - 1);
      end
      if (state == DIV) begin
        cnt <= cnt - 8'(cnt != 8'd0);
        if (!err) begin
          rem <= qbit ? rem_sh - {1'b0, q} : rem_sh;
          oU <= {oU[U_W-2:0], qbit};
        end
      end
    end
  end
endmodule
